ram_arbiter: RTL

- Shares the single-port mega_ram between two requesters:
  - port A: CPU datapath;
  - port B: loader/debug host that fills program/data words.
- Serialises accesses, drives RAM_ADDR/RAM_IN/RAM_WEN, and returns RAM_OUT read data with a one-cycle ACK.
- Sits between the CPU/loader and mega_ram in the cpu_rom_ram top level, clocked by CLK.

---
 rtl/ram_arb_pkg.sv | 21 ++
 rtl/ram_arb_pick.sv | 26 ++
 rtl/ram_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the mega_ram arbiter.
// Round-robin arbitration is selected by defining RAM_ARB_RR_EN.
package ram_arb_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    // Memory-mapped IO words; the arbiter passes them through like any other address.
    localparam logic [7:0] IO64_ADDR = 8'h40;
    localparam logic [7:0] IO65_ADDR = 8'h41;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection between port A and port B.
// RAM_ARB_RR_EN: round-robin on simultaneous requests; otherwise A has fixed priority.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
`ifdef RAM_ARB_RR_EN
    input  logic last_owner,
`endif
    output logic grant_b
);

    always_comb begin
`ifdef RAM_ARB_RR_EN
        if (a_req && b_req) begin
            grant_b = (last_owner == OWN_A);
        end else begin
            grant_b = b_req;
        end
`else
        grant_b = b_req && !a_req;
`endif
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the single-port mega_ram: IDLE -> ACCESS -> RESP per access.
// Define RAM_ARB_RR_EN for round-robin arbitration (default: A over B).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ram_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W = ram_arb_pkg::DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_WDATA,
    output logic              A_ACK,
    output logic [DATA_W-1:0] A_RDATA,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_WDATA,
    output logic              B_ACK,
    output logic [DATA_W-1:0] B_RDATA,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_IN,
    output logic              RAM_WEN,
    input  logic [DATA_W-1:0] RAM_OUT,
    output logic              BUSY,
    output logic              OWNER
);

    state_e              state_q, state_d;
    logic                we_q;
    logic                owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;
    logic                grant, grant_b;

    assign grant = (state_q == IDLE) && (A_REQ || B_REQ);

`ifdef RAM_ARB_RR_EN
    logic rr_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rr_q <= OWN_A;
        end else if (grant) begin
            rr_q <= grant_b;
        end
    end

    ram_arb_pick u_pick (
        .a_req      (A_REQ),
        .b_req      (B_REQ),
        .last_owner (rr_q),
        .grant_b    (grant_b)
    );
`else
    ram_arb_pick u_pick (
        .a_req   (A_REQ),
        .b_req   (B_REQ),
        .grant_b (grant_b)
    );
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (A_REQ || B_REQ) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latched request fields double as the registered RAM address/data bus.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            we_q      <= 1'b0;
            owner_q   <= OWN_A;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (grant) begin
                owner_q <= grant_b;
                we_q    <= grant_b ? B_WE    : A_WE;
                addr_q  <= grant_b ? B_ADDR  : A_ADDR;
                wdata_q <= grant_b ? B_WDATA : A_WDATA;
            end
            if (state_q == RESP && !we_q) begin
                if (owner_q == OWN_B) begin
                    b_rdata_q <= RAM_OUT;
                end else begin
                    a_rdata_q <= RAM_OUT;
                end
            end
        end
    end

    // RESET gates WEN/ACK so an aborted access neither writes nor completes.
    always_comb begin
        RAM_WEN = 1'b0;
        A_ACK   = 1'b0;
        B_ACK   = 1'b0;
        BUSY    = 1'b0;
        unique case (state_q)
            IDLE: ;
            ACCESS: begin
                BUSY    = 1'b1;
                RAM_WEN = we_q && !RESET;
            end
            RESP: begin
                BUSY  = 1'b1;
                A_ACK = !RESET && (owner_q == OWN_A);
                B_ACK = !RESET && (owner_q == OWN_B);
            end
            default: ;
        endcase
    end

    // Read data is presented straight from RAM_OUT during ACK, then held.
    assign A_RDATA  = (A_ACK && !we_q) ? RAM_OUT : a_rdata_q;
    assign B_RDATA  = (B_ACK && !we_q) ? RAM_OUT : b_rdata_q;
    assign RAM_ADDR = addr_q;
    assign RAM_IN   = wdata_q;
    assign OWNER    = owner_q;

endmodule
